// File: rtl/burst_arbiter.sv
// burst_arbiter: round-robin arbiter sharing one 6-bit datapath among NREQ requesters.
// Each grant is a burst of at most MAXBURST cycles, followed by GAP idle cycles.
// The grant, the grant index and the data output are all registered.
//
// Optional feature macro: BURST_ARB_FSM_CHECK_EN
//   defined   - one-hot state encoding with an integrity checker driving err
//   undefined - binary state encoding, err tied low
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]   per-requester request level
//   done     in   [NREQ]   early-release pulse, only the granted bit counts
//   din      in   [NREQ*6] flattened data, requester i at [6i+5:6i]
//   gnt      out  [NREQ]   one-hot grant
//   gnt_id   out  [IdW]    index of granted requester, holds when gnt is 0
//   busy     out  high in GRANT or GAP
//   dout     out  [6]      registered data of the granted requester
//   dout_vld out  dout valid strobe, one cycle behind gnt
//   err      out  FSM integrity error pulse
module burst_arbiter #(
   parameter int unsigned  NREQ     = 4,
   parameter int unsigned  MAXBURST = 5,
   parameter int unsigned  GAP      = 3,
   localparam int unsigned IdW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   done,
   input  logic [NREQ*6-1:0] din,
   output logic [NREQ-1:0]   gnt,
   output logic [IdW-1:0]    gnt_id,
   output logic              busy,
   output logic [5:0]        dout,
   output logic              dout_vld,
   output logic              err
);

`ifdef BURST_ARB_FSM_CHECK_EN
   typedef enum logic [2:0] {
      StIdle  = 3'b001,
      StGrant = 3'b010,
      StGap   = 3'b100
   } state_e;
`else
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StGap   = 2'd2
   } state_e;
`endif

   localparam bit HasGap = (GAP > 0);

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IdW-1:0]  gnt_id_q, gnt_id_d;
   logic [IdW-1:0]  last_id_q, last_id_d;
   logic [5:0]      dout_q, dout_d;
   logic            vld_q, vld_d;

   logic [IdW-1:0]  pick_id;
   logic [IdW-1:0]  cand;
   logic [5:0]      sel_data;
   logic            release_now;

   // Round-robin pick: first set req bit searching upward from last_id+1, wrapping.
   always_comb begin
      pick_id = '0;
      cand    = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         // Walk downward so the closest candidate (k = 1) is written last and wins.
         cand = IdW'((32'(last_id_q) + k) % NREQ);
         if (req[cand]) begin
            pick_id = cand;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_id_q == IdW'(i)) begin
            sel_data = din[6*i +: 6];
         end
      end
   end

   assign release_now = done[gnt_id_q] | ~req[gnt_id_q] | (cnt_q == 4'(MAXBURST));

`ifdef BURST_ARB_FSM_CHECK_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      last_id_d = last_id_q;
      dout_d    = dout_q;
      vld_d     = 1'b0;
`ifdef BURST_ARB_FSM_CHECK_EN
      err_d     = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (|req) begin
               state_d   = StGrant;
               gnt_d     = NREQ'(1) << pick_id;
               gnt_id_d  = pick_id;
               last_id_d = pick_id;
               cnt_d     = 4'd1;
            end
         end
         StGrant: begin
            // The exit edge still transfers data, so dout_vld matches the grant length.
            dout_d = sel_data;
            vld_d  = 1'b1;
            if (release_now) begin
               gnt_d = '0;
               if (HasGap) begin
                  state_d = StGap;
                  cnt_d   = 4'd1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StGap: begin
            if (cnt_q == 4'(GAP)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
`ifdef BURST_ARB_FSM_CHECK_EN
      // A corrupted state recovers to IDLE; last_id is kept so fairness survives.
      if (!$onehot(state_q)) begin
         state_d  = StIdle;
         gnt_d    = '0;
         gnt_id_d = gnt_id_q;
         dout_d   = dout_q;
         vld_d    = 1'b0;
         err_d    = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         last_id_q <= IdW'(NREQ - 1);
         dout_q    <= '0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         last_id_q <= last_id_d;
         dout_q    <= dout_d;
         vld_q     <= vld_d;
      end
   end

`ifdef BURST_ARB_FSM_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign gnt      = gnt_q;
   assign gnt_id   = gnt_id_q;
   assign busy     = (state_q == StGrant) || (state_q == StGap);
   assign dout     = dout_q;
   assign dout_vld = vld_q;

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed self-checking bench for burst_arbiter (NREQ=4, MAXBURST=5, GAP=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_burst_arbiter;

   localparam int unsigned NREQ = 4;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   done;
   logic [NREQ*6-1:0] din;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        gnt_id;
   logic              busy;
   logic [5:0]        dout;
   logic              dout_vld;
   logic              err;

   int total;
   int bad;

   burst_arbiter #(
      .NREQ     (4),
      .MAXBURST (5),
      .GAP      (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .din      (din),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .busy     (busy),
      .dout     (dout),
      .dout_vld (dout_vld),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      done = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = 4'hF;
      done = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if ({gnt, gnt_id, busy, dout, dout_vld, err} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs cyc=%0d got gnt=%b id=%0d busy=%b dout=%h vld=%b err=%b exp all 0",
                     c, gnt, gnt_id, busy, dout, dout_vld, err);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0001) begin
         bad++;
         $display("FAIL reset_first_grant got=%b exp=0001", gnt);
      end
   endtask

   task automatic test_single();
      logic [1:10] eg;
      logic [1:10] ev;
      logic [1:10] eb;
      eg = 10'b1111100001;
      ev = 10'b0111110000;
      eb = 10'b1111111101;
      do_reset();
      req = 4'b0100;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         total++;
         if (gnt !== (eg[c] ? 4'b0100 : 4'b0000)) begin
            bad++;
            $display("FAIL single_gnt cyc=%0d got=%b exp_high=%b", c, gnt, eg[c]);
         end
         total++;
         if (dout_vld !== ev[c]) begin
            bad++;
            $display("FAIL single_vld cyc=%0d got=%b exp=%b", c, dout_vld, ev[c]);
         end
         total++;
         if (busy !== eb[c]) begin
            bad++;
            $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, eb[c]);
         end
         if (ev[c]) begin
            total++;
            if (dout !== 6'h2A) begin
               bad++;
               $display("FAIL single_dout cyc=%0d got=%h exp=2a", c, dout);
            end
         end
         if (c == 7) begin
            total++;
            if (gnt_id !== 2'd2) begin
               bad++;
               $display("FAIL single_id_hold got=%0d exp=2", gnt_id);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_g;
      int         slot;
      do_reset();
      req = 4'hF;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         // Period of 9 cycles: 5 granted, 3 gap, 1 idle.
         slot  = (c - 1) / 9 % 4;
         exp_g = ((c - 1) % 9 < 5) ? (4'b0001 << slot) : 4'b0000;
         total++;
         if (gnt !== exp_g) begin
            bad++;
            $display("FAIL fair_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_g);
         end
         if (exp_g != 4'b0000) begin
            total++;
            if (gnt_id !== 2'(slot)) begin
               bad++;
               $display("FAIL fair_id cyc=%0d got=%0d exp=%0d", c, gnt_id, slot);
            end
         end
         total++;
         if (err !== 1'b0) begin
            bad++;
            $display("FAIL fair_err cyc=%0d got=%b exp=0", c, err);
         end
      end
      req = '0;
   endtask

   task automatic test_early_release();
      logic [1:11] eg;
      logic [1:11] ev;
      eg = 11'b11000011100;
      ev = 11'b01100001110;
      do_reset();
      req = 4'b0010;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         total++;
         if (gnt !== (eg[c] ? 4'b0010 : 4'b0000)) begin
            bad++;
            $display("FAIL early_gnt cyc=%0d got=%b exp_high=%b", c, gnt, eg[c]);
         end
         total++;
         if (dout_vld !== ev[c]) begin
            bad++;
            $display("FAIL early_vld cyc=%0d got=%b exp=%b", c, dout_vld, ev[c]);
         end
         if (c == 3) begin
            total++;
            if (dout !== 6'h22) begin
               bad++;
               $display("FAIL early_dout got=%h exp=22", dout);
            end
         end
         // done[3] in grant cycle 1 must be ignored, done[1] in grant cycle 2 ends it.
         if (c == 1)      done = 4'b1000;
         else if (c == 2) done = 4'b0010;
         else             done = 4'b0000;
         if (c >= 9) req = 4'b0000;
      end
   endtask

   task automatic test_done_at_max();
      logic [1:10] eg;
      eg = 10'b1111100001;
      do_reset();
      req = 4'b0001;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         total++;
         if (gnt !== (eg[c] ? 4'b0001 : 4'b0000)) begin
            bad++;
            $display("FAIL done_max_gnt cyc=%0d got=%b exp_high=%b", c, gnt, eg[c]);
         end
         done = (c == 5) ? 4'b0001 : 4'b0000;
      end
      req  = '0;
      done = '0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req = 4'b0100;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b1 || gnt !== 4'b0100) begin
         bad++;
         $display("FAIL midrst_pre got busy=%b gnt=%b exp busy=1 gnt=0100", busy, gnt);
      end
      rst = 1'b1;
      req = 4'hF;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || dout_vld !== 1'b0) begin
         bad++;
         $display("FAIL midrst_clear got gnt=%b busy=%b vld=%b exp 0000 0 0", gnt, busy, dout_vld);
      end
      total++;
      if (dout !== 6'h00 || gnt_id !== 2'd0) begin
         bad++;
         $display("FAIL midrst_regs got dout=%h id=%0d exp 00 0", dout, gnt_id);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
         bad++;
         $display("FAIL midrst_regrant got gnt=%b id=%0d exp 0001 0", gnt, gnt_id);
      end
      req = '0;
   endtask

`ifdef BURST_ARB_FSM_CHECK_EN
   task automatic test_fsm_check();
      do_reset();
      req = 4'b0001;
      repeat (2) @(negedge clk);
      force dut.state_q = 3'b011;
      #1;
      release dut.state_q;
      @(negedge clk);
      total++;
      if (err !== 1'b1 || gnt !== 4'b0000 || dout_vld !== 1'b0) begin
         bad++;
         $display("FAIL fsmchk_hit got err=%b gnt=%b vld=%b exp 1 0000 0", err, gnt, dout_vld);
      end
      @(negedge clk);
      total++;
      if (err !== 1'b0 || gnt !== 4'b0001) begin
         bad++;
         $display("FAIL fsmchk_recover got err=%b gnt=%b exp 0 0001", err, gnt);
      end
      req = '0;
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      din   = {6'h3C, 6'h2A, 6'h22, 6'h11};
      test_reset();
      test_single();
      test_fairness();
      test_early_release();
      test_done_at_max();
      test_reset_mid_burst();
`ifdef BURST_ARB_FSM_CHECK_EN
      test_fsm_check();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
